// File: rtl/wheel_kinematics.sv
// Mecanum inverse kinematics: body velocity (VX, VY, WZ) -> four wheel speeds, sign-magnitude Q8.
// One shared multiplier and adder, FSM sequenced. Optional WHEEL_KINEMATICS_SAT_EN: saturate instead of wrap.
module wheel_kinematics #(
   parameter int unsigned         N_WIDTH = 17,
   parameter int unsigned         Q_WIDTH = 8,
   parameter logic [N_WIDTH-1:0]  K_LXLY  = 17'd46,
   parameter logic [N_WIDTH-1:0]  INV_R   = 17'd3413
) (
   input  logic               WHEEL_KINEMATICS_CLOCK_50,
   input  logic               WHEEL_KINEMATICS_RESET_InHigh,
   input  logic               WHEEL_KINEMATICS_START_In,
   input  logic [N_WIDTH-1:0] WHEEL_KINEMATICS_VX_InBus,
   input  logic [N_WIDTH-1:0] WHEEL_KINEMATICS_VY_InBus,
   input  logic [N_WIDTH-1:0] WHEEL_KINEMATICS_WZ_InBus,
   output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_W1_OutBus,
   output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_W2_OutBus,
   output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_W3_OutBus,
   output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_W4_OutBus,
   output logic               WHEEL_KINEMATICS_BUSY_Out,
   output logic               WHEEL_KINEMATICS_DONE_Out
);

   localparam int unsigned M_WIDTH = N_WIDTH - 1;
   localparam int unsigned P_WIDTH = 2 * M_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCALE,
      S_ADD_A,
      S_ADD_B,
      S_MUL,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [N_WIDTH-1:0]   r_vx;
   logic [N_WIDTH-1:0]   r_vy;
   logic [N_WIDTH-1:0]   r_wz;
   logic [N_WIDTH-1:0]   r_kw;
   logic [N_WIDTH-1:0]   r_t;
   logic [N_WIDTH-1:0]   r_res [4];
   logic [1:0]           r_idx;
   logic [N_WIDTH-1:0]   r_w1;
   logic [N_WIDTH-1:0]   r_w2;
   logic [N_WIDTH-1:0]   r_w3;
   logic [N_WIDTH-1:0]   r_w4;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_flip_vy;
   logic                 w_flip_kw;
   logic [N_WIDTH-1:0]   w_add_a;
   logic [N_WIDTH-1:0]   w_add_b;
   logic [N_WIDTH-1:0]   w_mul_a;
   logic [N_WIDTH-1:0]   w_mul_b;
   logic [N_WIDTH-1:0]   w_add_y;
   logic [N_WIDTH-1:0]   w_mul_y;

   // Canonical zero: a zero magnitude never carries a negative sign.
   function automatic logic [N_WIDTH-1:0] f_canon(input logic s, input logic [M_WIDTH-1:0] m);
      return {s & (|m), m};
   endfunction

   function automatic logic [N_WIDTH-1:0] f_sm_add(input logic [N_WIDTH-1:0] a,
                                                   input logic [N_WIDTH-1:0] b);
      logic               sa;
      logic               sb;
      logic               sgn;
      logic [M_WIDTH-1:0] ma;
      logic [M_WIDTH-1:0] mb;
      logic [M_WIDTH-1:0] mag;
`ifdef WHEEL_KINEMATICS_SAT_EN
      logic [M_WIDTH:0]   sum;
`endif
      sa = a[N_WIDTH-1];
      sb = b[N_WIDTH-1];
      ma = a[M_WIDTH-1:0];
      mb = b[M_WIDTH-1:0];
      if (sa == sb) begin
`ifdef WHEEL_KINEMATICS_SAT_EN
         sum = {1'b0, ma} + {1'b0, mb};
         mag = sum[M_WIDTH] ? '1 : sum[M_WIDTH-1:0];
`else
         mag = ma + mb;
`endif
         sgn = sa;
      end else if (ma >= mb) begin
         mag = ma - mb;
         sgn = sa;
      end else begin
         mag = mb - ma;
         sgn = sb;
      end
      return f_canon(sgn, mag);
   endfunction

   // Product is truncated toward zero by dropping the Q_WIDTH fraction bits of the magnitude.
   function automatic logic [N_WIDTH-1:0] f_sm_mul(input logic [N_WIDTH-1:0] a,
                                                   input logic [N_WIDTH-1:0] b);
      logic [P_WIDTH-1:0] prod;
      logic [M_WIDTH-1:0] mag;
`ifdef WHEEL_KINEMATICS_SAT_EN
      logic [P_WIDTH-1:0] shifted;
`endif
      prod = P_WIDTH'(a[M_WIDTH-1:0]) * P_WIDTH'(b[M_WIDTH-1:0]);
`ifdef WHEEL_KINEMATICS_SAT_EN
      shifted = prod >> Q_WIDTH;
      mag     = (|shifted[P_WIDTH-1:M_WIDTH]) ? '1 : shifted[M_WIDTH-1:0];
`else
      mag     = M_WIDTH'(prod >> Q_WIDTH);
`endif
      return f_canon(a[N_WIDTH-1] ^ b[N_WIDTH-1], mag);
   endfunction

   // Wheels 1 and 4 subtract VY; wheels 1 and 3 subtract k*WZ.
   assign w_flip_vy = (r_idx == 2'd0) || (r_idx == 2'd3);
   assign w_flip_kw = (r_idx == 2'd0) || (r_idx == 2'd2);

   always_comb begin
      w_add_a = r_t;
      w_add_b = r_kw;
      w_mul_a = r_t;
      w_mul_b = INV_R;
      case (r_state)
         S_SCALE: begin
            w_mul_a = K_LXLY;
            w_mul_b = r_wz;
         end
         S_ADD_A: begin
            w_add_a = r_vx;
            w_add_b = w_flip_vy ? {~r_vy[N_WIDTH-1], r_vy[M_WIDTH-1:0]} : r_vy;
         end
         S_ADD_B: begin
            w_add_b = w_flip_kw ? {~r_kw[N_WIDTH-1], r_kw[M_WIDTH-1:0]} : r_kw;
         end
         default: ;
      endcase
   end

   assign w_add_y = f_sm_add(w_add_a, w_add_b);
   assign w_mul_y = f_sm_mul(w_mul_a, w_mul_b);

   always_ff @(posedge WHEEL_KINEMATICS_CLOCK_50 or posedge WHEEL_KINEMATICS_RESET_InHigh) begin
      if (WHEEL_KINEMATICS_RESET_InHigh) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (WHEEL_KINEMATICS_START_In) w_next = S_SCALE;
         S_SCALE: w_next = S_ADD_A;
         S_ADD_A: w_next = S_ADD_B;
         S_ADD_B: w_next = S_MUL;
         S_MUL:   w_next = (r_idx == 2'd3) ? S_DONE : S_ADD_A;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge WHEEL_KINEMATICS_CLOCK_50 or posedge WHEEL_KINEMATICS_RESET_InHigh) begin
      if (WHEEL_KINEMATICS_RESET_InHigh) begin
         r_vx   <= '0;
         r_vy   <= '0;
         r_wz   <= '0;
         r_kw   <= '0;
         r_t    <= '0;
         r_idx  <= 2'd0;
         r_w1   <= '0;
         r_w2   <= '0;
         r_w3   <= '0;
         r_w4   <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            r_res[k] <= '0;
         end
      end else begin
         r_busy <= (w_next != S_IDLE);
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (WHEEL_KINEMATICS_START_In) begin
                  r_vx <= WHEEL_KINEMATICS_VX_InBus;
                  r_vy <= WHEEL_KINEMATICS_VY_InBus;
                  r_wz <= WHEEL_KINEMATICS_WZ_InBus;
               end
               r_idx <= 2'd0;
            end
            S_SCALE: begin
               r_kw  <= w_mul_y;
               r_idx <= 2'd0;
            end
            S_ADD_A: r_t <= w_add_y;
            S_ADD_B: r_t <= w_add_y;
            S_MUL: begin
               r_res[r_idx] <= w_mul_y;
               r_idx        <= r_idx + 2'd1;
            end
            S_DONE: begin
               r_w1 <= r_res[0];
               r_w2 <= r_res[1];
               r_w3 <= r_res[2];
               r_w4 <= r_res[3];
            end
            default: ;
         endcase
      end
   end

   assign WHEEL_KINEMATICS_W1_OutBus = r_w1;
   assign WHEEL_KINEMATICS_W2_OutBus = r_w2;
   assign WHEEL_KINEMATICS_W3_OutBus = r_w3;
   assign WHEEL_KINEMATICS_W4_OutBus = r_w4;
   assign WHEEL_KINEMATICS_BUSY_Out  = r_busy;
   assign WHEEL_KINEMATICS_DONE_Out  = r_done;

endmodule

// File: tb/tb_wheel_kinematics.sv
// Self-checking bench for wheel_kinematics: directed cases plus randomized commands
// compared against an integer-arithmetic model of the wheel equations.
module tb_wheel_kinematics;

   localparam int unsigned NW = 17;
   localparam longint      KK = 128;
   localparam longint      GG = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NW-1:0] vx;
   logic [NW-1:0] vy;
   logic [NW-1:0] wz;
   logic [NW-1:0] w1;
   logic [NW-1:0] w2;
   logic [NW-1:0] w3;
   logic [NW-1:0] w4;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_pass   = 0;

   wheel_kinematics #(
      .N_WIDTH (17),
      .Q_WIDTH (8),
      .K_LXLY  (17'd128),
      .INV_R   (17'd512)
   ) dut (
      .WHEEL_KINEMATICS_CLOCK_50     (clk),
      .WHEEL_KINEMATICS_RESET_InHigh (rst),
      .WHEEL_KINEMATICS_START_In     (start),
      .WHEEL_KINEMATICS_VX_InBus     (vx),
      .WHEEL_KINEMATICS_VY_InBus     (vy),
      .WHEEL_KINEMATICS_WZ_InBus     (wz),
      .WHEEL_KINEMATICS_W1_OutBus    (w1),
      .WHEEL_KINEMATICS_W2_OutBus    (w2),
      .WHEEL_KINEMATICS_W3_OutBus    (w3),
      .WHEEL_KINEMATICS_W4_OutBus    (w4),
      .WHEEL_KINEMATICS_BUSY_Out     (busy),
      .WHEEL_KINEMATICS_DONE_Out     (done)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic longint sm2i(input logic [NW-1:0] v);
      longint m;
      m = longint'(v[NW-2:0]);
      return v[NW-1] ? -m : m;
   endfunction

   // Turn an exact integer result back into a canonical sign-magnitude word.
   function automatic logic [NW-1:0] i2sm(input longint r);
      longint m;
      m = (r < 0) ? -r : r;
`ifdef WHEEL_KINEMATICS_SAT_EN
      if (m > 65535) m = 65535;
`else
      m = m % 65536;
`endif
      if (m == 0) return '0;
      return {(r < 0) ? 1'b1 : 1'b0, 16'(m)};
   endfunction

   function automatic logic [NW-1:0] m_mul(input longint a, input longint b);
      longint m;
      m = (((a < 0) ? -a : a) * ((b < 0) ? -b : b)) / 256;
      return i2sm(((a < 0) != (b < 0)) ? -m : m);
   endfunction

   function automatic logic [NW-1:0] model_wheel(input int i, input logic [NW-1:0] a,
                                                 input logic [NW-1:0] b, input logic [NW-1:0] c);
      longint        sy;
      longint        sk;
      logic [NW-1:0] kw;
      logic [NW-1:0] t;
      sy = (i == 0 || i == 3) ? -1 : 1;
      sk = (i == 0 || i == 2) ? -1 : 1;
      kw = m_mul(KK, sm2i(c));
      t  = i2sm(sm2i(a) + sy * sm2i(b));
      t  = i2sm(sm2i(t) + sk * sm2i(kw));
      return m_mul(sm2i(t), GG);
   endfunction

   task automatic pulse_start(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic [NW-1:0] c);
      @(negedge clk);
      vx = a; vy = b; wz = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input logic [NW-1:0] a,
                                input logic [NW-1:0] b, input logic [NW-1:0] c);
      chk({tag, "_w1"}, 32'(w1), 32'(model_wheel(0, a, b, c)));
      chk({tag, "_w2"}, 32'(w2), 32'(model_wheel(1, a, b, c)));
      chk({tag, "_w3"}, 32'(w3), 32'(model_wheel(2, a, b, c)));
      chk({tag, "_w4"}, 32'(w4), 32'(model_wheel(3, a, b, c)));
   endtask

   task automatic run_op(input string tag, input logic [NW-1:0] a,
                         input logic [NW-1:0] b, input logic [NW-1:0] c);
      int n;
      int busy_cnt;
      pulse_start(a, b, c);
      n = 0;
      busy_cnt = 0;
      while (!done && n < 40) begin
         busy_cnt += int'(busy);
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd14);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd14);
      check_outputs(tag, a, b, c);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, "_hold_w2"}, 32'(w2), 32'(model_wheel(1, a, b, c)));
   endtask

   initial begin
      logic [NW-1:0] ra;
      logic [NW-1:0] rb;
      logic [NW-1:0] rc;
      int dcnt;
      logic [NW-1:0] cap [4];

      rst = 1'b1; start = 1'b0; vx = '0; vy = '0; wz = '0;
      repeat (3) @(negedge clk);
      chk("rst_w1", 32'(w1), 32'd0);
      chk("rst_w4", 32'(w4), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_in_reset_ignored", 32'(busy), 32'd0);

      run_op("vx1", 17'h00100, 17'h00000, 17'h00000);
      chk("vx1_w1_const", 32'(w1), 32'h00200);
      chk("vx1_w4_const", 32'(w4), 32'h00200);
      run_op("vy1", 17'h00000, 17'h00100, 17'h00000);
      chk("vy1_w1_const", 32'(w1), 32'h10200);
      chk("vy1_w2_const", 32'(w2), 32'h00200);
      chk("vy1_w4_const", 32'(w4), 32'h10200);
      run_op("wz1", 17'h00000, 17'h00000, 17'h00100);
      chk("wz1_w1_const", 32'(w1), 32'h10100);
      chk("wz1_w2_const", 32'(w2), 32'h00100);
      chk("wz1_w3_const", 32'(w3), 32'h10100);
      run_op("big", 17'h0C800, 17'h0C800, 17'h00000);
`ifdef WHEEL_KINEMATICS_SAT_EN
      chk("sat_w1", 32'(w1), 32'h00000);
      chk("sat_w2", 32'(w2), 32'h0FFFF);
      chk("sat_w3", 32'(w3), 32'h0FFFF);
      chk("sat_w4", 32'(w4), 32'h00000);
`endif

      // Second START three cycles into a run must be ignored.
      pulse_start(17'h00300, 17'h10080, 17'h00040);
      repeat (2) @(negedge clk);
      vx = 17'h05000; vy = 17'h00700; wz = 17'h10900; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcnt = 0;
      for (int k = 0; k < 4; k++) cap[k] = '0;
      for (int c = 0; c < 30; c++) begin
         if (done) begin
            dcnt++;
            cap[0] = w1; cap[1] = w2; cap[2] = w3; cap[3] = w4;
         end
         @(negedge clk);
      end
      chk("ignore_done_count", 32'(dcnt), 32'd1);
      for (int k = 0; k < 4; k++)
         chk($sformatf("ignore_w%0d", k + 1), 32'(cap[k]), 32'(model_wheel(k, 17'h00300, 17'h10080, 17'h00040)));

      // Reset mid-run aborts asynchronously.
      run_op("pre_rst", 17'h00240, 17'h00110, 17'h10050);
      pulse_start(17'h00400, 17'h00100, 17'h00100);
      repeat (5) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_w1", 32'(w1), 32'd0);
      chk("abort_w2", 32'(w2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) dcnt++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      run_op("post_rst", 17'h00180, 17'h10020, 17'h00300);

      for (int r = 0; r < 25; r++) begin
         ra = {1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535) >> $urandom_range(0, 10))};
         rb = {1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535) >> $urandom_range(0, 10))};
         rc = {1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535) >> $urandom_range(0, 10))};
         run_op($sformatf("rnd%0d", r), ra, rb, rc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
